mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs. Performs load/store accesses on a req/gnt/rvalid data-memory bus.
- Stalls upstream stages while an access is outstanding.
- Drives registered writeback fields toward WB, acting as the MEM/WB boundary.
- Non-memory instructions pass through to WB with 1-cycle latency.

Parameters:
- TIMEOUT_CYCLES, 16, cycles allowed in REQ+WAIT before the access aborts with bus error (must be >=2).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM slot holds a valid instruction.
- mem_alu_result  in  32  effective address, or ALU result for non-memory ops.
- mem_rs2_val  in  32  store data.
- mem_rd  in  5  destination register.
- mem_mem_read  in  1  load.
- mem_mem_write  in  1  store. Never asserted together with mem_mem_read.
- mem_reg_write  in  1  instruction writes rd.
- mem_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_jal  in  1  writeback selects mem_pc_plus4.
- mem_pc_plus4  in  32  link value.
- mem_stall  out  1  upstream must hold its EX/MEM contents this cycle.
- dmem_req  out  1  bus request, registered.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  byte address.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  response valid (read data or write ack).
- dmem_rdata  in  32  read data.
- dmem_err  in  1  response error, qualified by dmem_rvalid.
- wb_valid  out  1  one-cycle pulse: wb_* fields are new.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  register write enable.
- wb_wdata  out  32  writeback data.
- misalign_exc  out  1  pulse alongside wb_valid.
- bus_err_exc  out  1  pulse alongside wb_valid.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, timeout counter=0, all outputs 0. An in-flight access is abandoned and dmem_req drops immediately.
- Memory op = in_valid & (mem_mem_read | mem_mem_write).
- Misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=0.

FSM:
- IDLE:
  - Non-memory valid op: next cycle wb_valid=1, wb_rd=mem_rd, wb_reg_write=mem_reg_write, wb_wdata = mem_jal ? mem_pc_plus4 : mem_alu_result.
  - Misaligned memory op: no bus activity. Next cycle wb_valid=1, misalign_exc=1, wb_reg_write=0.
  - Aligned memory op: capture all op fields, mem_stall=1 (combinational), go to REQ.
- REQ:
  - dmem_req=1; addr/we/be/wdata held stable from the captured op.
  - On gnt: deassert req next cycle and go to WAIT, unless rvalid arrives in the same cycle, which completes immediately.
- WAIT:
  - Wait for rvalid.
  - Completion cycle (rvalid seen): mem_stall=0; state->IDLE; next cycle wb_valid=1.
  - Load: wb_reg_write=captured reg_write & !err; wb_wdata = extracted lane (addr[1:0] byte / addr[1] half), sign-extended for B/H, zero-extended for BU/HU/W.
  - Store: wb_reg_write=0.
  - If dmem_err: bus_err_exc=1, wb_reg_write=0.
- Timeout: counter increments each cycle in REQ/WAIT and clears on IDLE entry. When it reaches TIMEOUT_CYCLES-1 with no completion, that cycle is the completion cycle: bus_err_exc=1, wb_reg_write=0, dmem_req drops, state->IDLE.

Stall, handshakes, encodings:
- mem_stall = (IDLE & aligned memory op) | REQ | WAIT, except 0 in the completion cycle. Upstream therefore advances exactly on the completion edge; the same op is never re-accepted.
- Store encoding:
  - SB: be=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
  - For loads: be as for the same size, we=0, wdata=0.
- wb_valid, misalign_exc and bus_err_exc are single-cycle pulses. Other wb_* fields hold their last value.
- in_valid=0 in IDLE produces wb_valid=0 next cycle.
- gnt or rvalid arriving in IDLE is ignored.

Test Plan:
- Non-memory op: addr=0x1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_wdata=0x1234, mem_stall=0 throughout. With mem_jal=1, pc_plus4=0x40 -> wb_wdata=0x40.
- LB from 0x103, gnt after 2 cycles, rvalid 1 cycle later with rdata=0x80FF_FFFF -> be=1000, stall high 4 cycles, wb_wdata=0xFFFF_FF80. Repeat as LBU -> 0x0000_0080.
- SH 0xABCD to 0x202 with same-cycle gnt+rvalid -> be=1100, wdata=0xABCD_ABCD, one REQ cycle, wb_valid=1 with wb_reg_write=0.
- LW at 0x102 -> dmem_req never rises; wb_valid=1, misalign_exc=1, wb_reg_write=0.
- Load granted but rvalid never returns, TIMEOUT_CYCLES=16 -> stall drops on the 16th REQ/WAIT cycle, bus_err_exc=1. Also: rvalid with dmem_err=1 -> bus_err_exc=1, wb_reg_write=0.
- reset_n asserted while in WAIT -> dmem_req, mem_stall and wb_* immediately 0. After release, the next op is handled from IDLE and a stray rvalid is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store unit sitting between the EX/MEM pipeline register
//   and WB. Memory ops are issued on a req/gnt/rvalid data bus; upstream is
//   stalled until the access completes, errors or times out. Non-memory ops
//   pass straight through to the registered writeback fields (1-cycle).
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   in_valid, mem_*         EX/MEM slot contents
//   mem_stall               upstream must hold EX/MEM this cycle
//   dmem_req/we/addr/wdata/be, dmem_gnt/rvalid/rdata/err   data bus
//   wb_valid/rd/reg_write/wdata                             MEM/WB fields
//   misalign_exc, bus_err_exc                               exception pulses
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_rs2_val,
    input  logic [4:0]  mem_rd,
    input  logic        mem_mem_read,
    input  logic        mem_mem_write,
    input  logic        mem_reg_write,
    input  logic [2:0]  mem_funct3,
    input  logic        mem_jal,
    input  logic [31:0] mem_pc_plus4,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_err,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_wdata,
    output logic        misalign_exc,
    output logic        bus_err_exc
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [4:0]      op_rd;
    logic            op_reg_write;
    logic [2:0]      op_funct3;

    logic            mem_op, misaligned;
    logic            accept, passthru, misalign_now;
    logic            complete, resp, err_now, timeout_hit;
    logic [3:0]      be_new;
    logic [31:0]     wdata_new, shifted, load_data;

    assign mem_op      = in_valid & (mem_mem_read | mem_mem_write);
    assign misaligned  = ((mem_funct3[1:0] == 2'b01) & mem_alu_result[0]) |
                         ((mem_funct3[1:0] == 2'b10) & (mem_alu_result[1:0] != 2'b00));
    assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = mem_rs2_val;
        case (mem_funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << mem_alu_result[1:0];
                wdata_new = {4{mem_rs2_val[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << mem_alu_result[1:0];
                wdata_new = {2{mem_rs2_val[15:0]}};
            end
            default: ;
        endcase
        if (!mem_mem_write) wdata_new = '0;
    end

    // Addresses of aligned halves have addr[0]=0, so the byte-lane shift also
    // selects the correct halfword.
    assign shifted = dmem_rdata >> {dmem_addr[1:0], 3'b000};

    always_comb begin
        case (op_funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'b0, shifted[7:0]};
            3'b101:  load_data = {16'b0, shifted[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        passthru     = 1'b0;
        misalign_now = 1'b0;
        complete     = 1'b0;
        resp         = 1'b0;
        err_now      = 1'b0;
        mem_stall    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        misalign_now = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        mem_stall  = 1'b1;
                        next_state = ST_REQ;
                    end
                end else if (in_valid) begin
                    passthru = 1'b1;
                end
            end
            ST_REQ: begin
                if (dmem_gnt && dmem_rvalid) begin
                    complete = 1'b1;
                    resp     = 1'b1;
                    err_now  = dmem_err;
                end else if (timeout_hit) begin
                    complete = 1'b1;
                    err_now  = 1'b1;
                end else if (dmem_gnt) begin
                    next_state = ST_WAIT;
                end
                mem_stall = ~complete;
                if (complete) next_state = ST_IDLE;
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    complete = 1'b1;
                    resp     = 1'b1;
                    err_now  = dmem_err;
                end else if (timeout_hit) begin
                    complete = 1'b1;
                    err_now  = 1'b1;
                end
                mem_stall = ~complete;
                if (complete) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            op_rd        <= '0;
            op_reg_write <= 1'b0;
            op_funct3    <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_wdata     <= '0;
            misalign_exc <= 1'b0;
            bus_err_exc  <= 1'b0;
        end else begin
            state    <= next_state;
            dmem_req <= (next_state == ST_REQ);
            if (next_state == ST_IDLE || state == ST_IDLE) cnt <= '0;
            else                                           cnt <= cnt + 1'b1;

            if (accept) begin
                dmem_we      <= mem_mem_write;
                dmem_addr    <= mem_alu_result;
                dmem_wdata   <= wdata_new;
                dmem_be      <= be_new;
                op_rd        <= mem_rd;
                op_reg_write <= mem_reg_write;
                op_funct3    <= mem_funct3;
            end

            wb_valid     <= passthru | misalign_now | complete;
            misalign_exc <= misalign_now;
            bus_err_exc  <= complete & err_now;

            if (passthru) begin
                wb_rd        <= mem_rd;
                wb_reg_write <= mem_reg_write;
                wb_wdata     <= mem_jal ? mem_pc_plus4 : mem_alu_result;
            end else if (misalign_now) begin
                wb_rd        <= mem_rd;
                wb_reg_write <= 1'b0;
            end else if (complete) begin
                wb_rd        <= op_rd;
                wb_reg_write <= op_reg_write & ~dmem_we & ~err_now;
                if (resp && !dmem_we) wb_wdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] mem_alu_result, mem_rs2_val, mem_pc_plus4;
    logic [4:0]  mem_rd;
    logic        mem_mem_read, mem_mem_write, mem_reg_write, mem_jal;
    logic [2:0]  mem_funct3;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid, dmem_err;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_reg_write, misalign_exc, bus_err_exc;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;

    int tests = 0;
    int fails = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .mem_alu_result(mem_alu_result), .mem_rs2_val(mem_rs2_val), .mem_rd(mem_rd),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_reg_write(mem_reg_write), .mem_funct3(mem_funct3), .mem_jal(mem_jal),
        .mem_pc_plus4(mem_pc_plus4), .mem_stall(mem_stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .dmem_err(dmem_err), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_wdata(wb_wdata),
        .misalign_exc(misalign_exc), .bus_err_exc(bus_err_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic rd_op, input logic wr_op,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [4:0] rd, input logic rw);
        in_valid       = v;
        mem_mem_read   = rd_op;
        mem_mem_write  = wr_op;
        mem_funct3     = f3;
        mem_alu_result = addr;
        mem_rs2_val    = rs2;
        mem_rd         = rd;
        mem_reg_write  = rw;
        mem_jal        = 1'b0;
        mem_pc_plus4   = 32'h0;
    endtask

    initial begin
        reset_n = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; dmem_err = 1'b0;
        #22;
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_stall", {31'b0, mem_stall}, 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'h0);
        reset_n = 1'b1;
        cyc();

        // Non-memory pass-through, then JAL link value
        set_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
        #1 chk("alu_stall", {31'b0, mem_stall}, 32'd0);
        cyc();
        chk("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("alu_wb_wdata", wb_wdata, 32'h1234);
        chk("alu_wb_rd", {27'b0, wb_rd}, 32'd5);
        chk("alu_wb_rw", {31'b0, wb_reg_write}, 32'd1);
        mem_jal = 1'b1; mem_pc_plus4 = 32'h40;
        cyc();
        chk("jal_wb_wdata", wb_wdata, 32'h40);
        chk("jal_wb_valid", {31'b0, wb_valid}, 32'd1);
        in_valid = 1'b0;
        cyc();
        chk("idle_wb_valid", {31'b0, wb_valid}, 32'd0);

        // LB from 0x103: 3 REQ cycles (gnt on the third), then WAIT with rvalid
        set_op(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1);
        #1 chk("lb_stall0", {31'b0, mem_stall}, 32'd1);
        chk("lb_req0", {31'b0, dmem_req}, 32'd0);
        cyc();
        chk("lb_req1", {31'b0, dmem_req}, 32'd1);
        chk("lb_addr", dmem_addr, 32'h103);
        chk("lb_be", {28'b0, dmem_be}, 32'b1000);
        chk("lb_we", {31'b0, dmem_we}, 32'd0);
        chk("lb_wdata", dmem_wdata, 32'h0);
        chk("lb_stall1", {31'b0, mem_stall}, 32'd1);
        cyc();
        chk("lb_stall2", {31'b0, mem_stall}, 32'd1);
        cyc();
        dmem_gnt = 1'b1;
        #1 chk("lb_stall3", {31'b0, mem_stall}, 32'd1);
        cyc();
        dmem_gnt = 1'b0;
        chk("lb_req_wait", {31'b0, dmem_req}, 32'd0);
        in_valid = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FFFF;
        #1 chk("lb_stall4", {31'b0, mem_stall}, 32'd0);
        cyc();
        dmem_rvalid = 1'b0;
        chk("lb_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("lb_wb_wdata", wb_wdata, 32'hFFFF_FF80);
        chk("lb_wb_rd", {27'b0, wb_rd}, 32'd7);
        chk("lb_wb_rw", {31'b0, wb_reg_write}, 32'd1);
        chk("lb_bus_err", {31'b0, bus_err_exc}, 32'd0);

        // LBU from 0x103: gnt in first REQ cycle, rvalid next cycle
        set_op(1'b1, 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd8, 1'b1);
        cyc();
        dmem_gnt = 1'b1;
        cyc();
        dmem_gnt = 1'b0; in_valid = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FFFF;
        cyc();
        dmem_rvalid = 1'b0;
        chk("lbu_wb_wdata", wb_wdata, 32'h0000_0080);
        chk("lbu_wb_valid", {31'b0, wb_valid}, 32'd1);

        // SH 0xABCD to 0x202 with same-cycle gnt+rvalid
        set_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 5'd9, 1'b1);
        cyc();
        chk("sh_req", {31'b0, dmem_req}, 32'd1);
        chk("sh_we", {31'b0, dmem_we}, 32'd1);
        chk("sh_be", {28'b0, dmem_be}, 32'b1100);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_addr", dmem_addr, 32'h202);
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; in_valid = 1'b0;
        #1 chk("sh_stall", {31'b0, mem_stall}, 32'd0);
        cyc();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        chk("sh_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("sh_wb_rw", {31'b0, wb_reg_write}, 32'd0);
        chk("sh_req_drop", {31'b0, dmem_req}, 32'd0);

        // Misaligned LW at 0x102
        set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd10, 1'b1);
        #1 chk("mis_stall", {31'b0, mem_stall}, 32'd0);
        cyc();
        in_valid = 1'b0;
        chk("mis_req", {31'b0, dmem_req}, 32'd0);
        chk("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("mis_exc", {31'b0, misalign_exc}, 32'd1);
        chk("mis_wb_rw", {31'b0, wb_reg_write}, 32'd0);
        cyc();
        chk("mis_exc_pulse", {31'b0, misalign_exc}, 32'd0);
        chk("mis_req_after", {31'b0, dmem_req}, 32'd0);

        // Timeout: LW granted in first REQ cycle, no rvalid ever
        set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd11, 1'b1);
        cyc();
        chk("to_stall1", {31'b0, mem_stall}, 32'd1);
        dmem_gnt = 1'b1;
        for (int k = 2; k <= 16; k++) begin
            cyc();
            dmem_gnt = 1'b0;
            if (k == 16) in_valid = 1'b0;
            chk($sformatf("to_stall%0d", k), {31'b0, mem_stall}, (k < 16) ? 32'd1 : 32'd0);
        end
        cyc();
        chk("to_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("to_bus_err", {31'b0, bus_err_exc}, 32'd1);
        chk("to_wb_rw", {31'b0, wb_reg_write}, 32'd0);
        chk("to_req", {31'b0, dmem_req}, 32'd0);

        // Error response on rvalid
        set_op(1'b1, 1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 5'd12, 1'b1);
        cyc();
        dmem_gnt = 1'b1;
        cyc();
        dmem_gnt = 1'b0; in_valid = 1'b0;
        dmem_rvalid = 1'b1; dmem_err = 1'b1; dmem_rdata = 32'h12;
        cyc();
        dmem_rvalid = 1'b0; dmem_err = 1'b0;
        chk("err_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("err_bus_err", {31'b0, bus_err_exc}, 32'd1);
        chk("err_wb_rw", {31'b0, wb_reg_write}, 32'd0);
        cyc();
        chk("err_pulse", {31'b0, bus_err_exc}, 32'd0);

        // Reset asserted while in WAIT
        set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd13, 1'b1);
        cyc();
        dmem_gnt = 1'b1;
        cyc();
        dmem_gnt = 1'b0;
        chk("rw_stall_pre", {31'b0, mem_stall}, 32'd1);
        #2 reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rw_req", {31'b0, dmem_req}, 32'd0);
        chk("rw_stall", {31'b0, mem_stall}, 32'd0);
        chk("rw_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rw_wb_rd", {27'b0, wb_rd}, 32'd0);
        chk("rw_wb_wdata", wb_wdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        cyc();
        dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
        chk("stray_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("stray_stall", {31'b0, mem_stall}, 32'd0);
        set_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd3, 1'b1);
        cyc();
        in_valid = 1'b0;
        chk("post_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("post_wb_wdata", wb_wdata, 32'h55);
        chk("post_wb_rd", {27'b0, wb_rd}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
